blit_cmd_decoder: RTL and testbench

- Sits directly downstream of the blitter command FIFO and consumes its 33-bit entries: bit 32 is the privilege flag, bits 31:0 are the command word.
- Parses variable-length commands (one header word plus 0-3 argument words).
- Applies state-setting commands to held state registers.
- Issues draw operations to the blit engine over a valid/ready handshake.
- Rejects privileged commands that arrive from unprivileged sources.

---
 rtl/blit_pkg.sv | 56 +++++
 rtl/blit_state_regs.sv | 45 ++++
 rtl/blit_cmd_decoder.sv | 170 +++++++++++++++++
 tb/tb_blit_cmd_decoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared opcode/state definitions and opcode-table helpers for the blitter command decoder.
package blit_pkg;

  typedef enum logic [7:0] {
    OP_NOP       = 8'h00,
    OP_SET_DEST  = 8'h01,
    OP_SET_CLIP  = 8'h02,
    OP_SET_FG    = 8'h03,
    OP_SET_BG    = 8'h04,
    OP_FILL_RECT = 8'h10,
    OP_COPY_RECT = 8'h11,
    OP_LINE      = 8'h12,
    OP_BLIT_MONO = 8'h13
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARGS,
    S_EXEC,
    S_ISSUE
  } dec_state_e;

  typedef struct packed {
    logic [7:0]       code;
    logic [23:0]      imm;
    logic [0:2][31:0] arg;
  } blit_op_t;

  function automatic logic [1:0] arg_count(input logic [7:0] op);
    case (op)
      OP_SET_DEST, OP_SET_CLIP, OP_FILL_RECT, OP_LINE: arg_count = 2'd2;
      OP_COPY_RECT, OP_BLIT_MONO:                      arg_count = 2'd3;
      default:                                         arg_count = 2'd0;
    endcase
  endfunction

  function automatic logic is_privileged(input logic [7:0] op);
    is_privileged = (op == OP_SET_DEST);
  endfunction

  function automatic logic is_draw(input logic [7:0] op);
    case (op)
      OP_FILL_RECT, OP_COPY_RECT, OP_LINE, OP_BLIT_MONO: is_draw = 1'b1;
      default:                                           is_draw = 1'b0;
    endcase
  endfunction

  function automatic logic is_known(input logic [7:0] op);
    case (op)
      OP_NOP, OP_SET_DEST, OP_SET_CLIP, OP_SET_FG, OP_SET_BG,
      OP_FILL_RECT, OP_COPY_RECT, OP_LINE, OP_BLIT_MONO: is_known = 1'b1;
      default:                                           is_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/blit_state_regs.sv
// Held blitter state (destination, clip, colours), updated by SET_* commands when enabled.
module blit_state_regs
  import blit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  code,
  input  logic [23:0] imm,
  input  logic [31:0] arg0,
  input  logic [31:0] arg1,
  output logic [31:0] st_dest_base,
  output logic [15:0] st_dest_pitch,
  output logic [31:0] st_clip_tl,
  output logic [31:0] st_clip_br,
  output logic [31:0] st_fg_color,
  output logic [31:0] st_bg_color
);

  always_ff @(posedge clock) begin
    if (reset) begin
      st_dest_base  <= '0;
      st_dest_pitch <= '0;
      st_clip_tl    <= '0;
      st_clip_br    <= '0;
      st_fg_color   <= '0;
      st_bg_color   <= '0;
    end else if (en) begin
      case (code)
        OP_SET_DEST: begin
          st_dest_base  <= arg0;
          st_dest_pitch <= arg1[15:0];
        end
        OP_SET_CLIP: begin
          st_clip_tl <= arg0;
          st_clip_br <= arg1;
        end
        OP_SET_FG: st_fg_color <= {8'h00, imm};
        OP_SET_BG: st_bg_color <= {8'h00, imm};
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/blit_cmd_decoder.sv
// Blitter command decoder: parses FIFO entries, updates held state, issues draw ops.
// Optional command/reject counters under `BLIT_CMD_STATS_EN.
module blit_cmd_decoder
  import blit_pkg::*;
#(
  parameter int unsigned MAX_ARGS = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_queue_valid,
  input  logic [32:0] cmd_queue_data,
  output logic        cmd_queue_ready,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [7:0]  op_code,
  output logic [23:0] op_imm,
  output logic [31:0] op_arg0,
  output logic [31:0] op_arg1,
  output logic [31:0] op_arg2,
  output logic [31:0] st_dest_base,
  output logic [15:0] st_dest_pitch,
  output logic [31:0] st_clip_tl,
  output logic [31:0] st_clip_br,
  output logic [31:0] st_fg_color,
  output logic [31:0] st_bg_color,
  output logic        busy,
  output logic        err_priv,
  output logic        err_opcode,
  input  logic        err_clear
`ifdef BLIT_CMD_STATS_EN
  ,
  output logic [31:0] stat_cmds,
  output logic [15:0] stat_rejects
`endif
);

  localparam int unsigned CNT_W = (MAX_ARGS > 1) ? $clog2(MAX_ARGS + 1) : 1;

  dec_state_e                 state, state_next;
  logic [7:0]                 code_q;
  logic [23:0]                imm_q;
  logic                       priv_q;
  logic [CNT_W-1:0]           arg_cnt;
  logic [MAX_ARGS-1:0][31:0]  arg_buf;
  logic [31:0]                arg_view [3];
  blit_op_t                   op_q;

  logic [7:0] hdr_code;
  logic       accept, hdr_zero, last_arg, rejected;
  logic       upd_en, priv_evt, opc_evt;

  assign hdr_code = cmd_queue_data[31:24];
  assign accept   = cmd_queue_valid && cmd_queue_ready;
  assign hdr_zero = (arg_count(hdr_code) == 2'd0);
  assign last_arg = (arg_cnt == CNT_W'(arg_count(code_q)) - CNT_W'(1));
  assign rejected = is_privileged(code_q) && !priv_q;

  // Buffer slots beyond MAX_ARGS read as zero so op_arg* stay well-defined.
  for (genvar g = 0; g < 3; g++) begin : g_arg_view
    if (g < MAX_ARGS) begin : g_live
      assign arg_view[g] = arg_buf[g];
    end else begin : g_zero
      assign arg_view[g] = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (accept && !hdr_zero) state_next = S_ARGS;
      S_ARGS:  if (accept && last_arg)  state_next = S_EXEC;
      S_EXEC:  state_next = (is_draw(code_q) && !rejected) ? S_ISSUE : S_IDLE;
      S_ISSUE: if (op_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_queue_ready = (state == S_IDLE) || (state == S_ARGS);
    op_valid        = (state == S_ISSUE);
    busy            = (state != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      code_q  <= '0;
      imm_q   <= '0;
      priv_q  <= 1'b0;
      arg_cnt <= '0;
      arg_buf <= '0;
      op_q    <= '0;
    end else begin
      if (state == S_IDLE && accept) begin
        code_q  <= hdr_code;
        imm_q   <= cmd_queue_data[23:0];
        priv_q  <= cmd_queue_data[32];
        arg_cnt <= '0;
        arg_buf <= '0;
      end
      if (state == S_ARGS && accept) begin
        arg_buf[arg_cnt] <= cmd_queue_data[31:0];
        arg_cnt          <= arg_cnt + CNT_W'(1);
      end
      if (state == S_EXEC && is_draw(code_q) && !rejected) begin
        op_q.code <= code_q;
        op_q.imm  <= imm_q;
        for (int unsigned i = 0; i < 3; i++) op_q.arg[i] <= arg_view[i];
      end
    end
  end

  assign op_code = op_q.code;
  assign op_imm  = op_q.imm;
  assign op_arg0 = op_q.arg[0];
  assign op_arg1 = op_q.arg[1];
  assign op_arg2 = op_q.arg[2];

  // Zero-argument commands execute straight from the header; others from latched fields in EXEC.
  assign upd_en   = (state == S_IDLE && accept && hdr_zero) || (state == S_EXEC && !rejected);
  assign priv_evt = (state == S_EXEC) && rejected;
  assign opc_evt  = (state == S_IDLE) && accept && !is_known(hdr_code);

  blit_state_regs u_state_regs (
    .clock         (clock),
    .reset         (reset),
    .en            (upd_en),
    .code          ((state == S_EXEC) ? code_q : hdr_code),
    .imm           ((state == S_EXEC) ? imm_q : cmd_queue_data[23:0]),
    .arg0          (arg_view[0]),
    .arg1          (arg_view[1]),
    .st_dest_base  (st_dest_base),
    .st_dest_pitch (st_dest_pitch),
    .st_clip_tl    (st_clip_tl),
    .st_clip_br    (st_clip_br),
    .st_fg_color   (st_fg_color),
    .st_bg_color   (st_bg_color)
  );

  // A new error in the same cycle as err_clear keeps the bit set.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_priv   <= 1'b0;
      err_opcode <= 1'b0;
    end else begin
      err_priv   <= priv_evt || (err_priv && !err_clear);
      err_opcode <= opc_evt || (err_opcode && !err_clear);
    end
  end

`ifdef BLIT_CMD_STATS_EN
  logic exec_done;
  assign exec_done = (state == S_EXEC) || (state == S_IDLE && accept && hdr_zero);

  always_ff @(posedge clock) begin
    if (reset || err_clear) begin
      stat_cmds    <= '0;
      stat_rejects <= '0;
    end else begin
      if (exec_done && stat_cmds != '1)                 stat_cmds    <= stat_cmds + 32'd1;
      if ((priv_evt || opc_evt) && stat_rejects != '1) stat_rejects <= stat_rejects + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_blit_cmd_decoder.sv
// Directed self-checking bench for blit_cmd_decoder; one task per scenario.
module tb_blit_cmd_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_queue_valid = 1'b0;
  logic [32:0] cmd_queue_data = '0;
  logic        cmd_queue_ready;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [7:0]  op_code;
  logic [23:0] op_imm;
  logic [31:0] op_arg0, op_arg1, op_arg2;
  logic [31:0] st_dest_base;
  logic [15:0] st_dest_pitch;
  logic [31:0] st_clip_tl, st_clip_br, st_fg_color, st_bg_color;
  logic        busy, err_priv, err_opcode;
  logic        err_clear = 1'b0;
`ifdef BLIT_CMD_STATS_EN
  logic [31:0] stat_cmds;
  logic [15:0] stat_rejects;
`endif

  int passed = 0;
  int total  = 0;
  int xfers  = 0;
  logic [7:0]  cap_code;
  logic [23:0] cap_imm;
  logic [31:0] cap_a0, cap_a1, cap_a2;

  always #5 clock = ~clock;

  blit_cmd_decoder #(.MAX_ARGS(3)) dut (
    .clock           (clock),
    .reset           (reset),
    .cmd_queue_valid (cmd_queue_valid),
    .cmd_queue_data  (cmd_queue_data),
    .cmd_queue_ready (cmd_queue_ready),
    .op_valid        (op_valid),
    .op_ready        (op_ready),
    .op_code         (op_code),
    .op_imm          (op_imm),
    .op_arg0         (op_arg0),
    .op_arg1         (op_arg1),
    .op_arg2         (op_arg2),
    .st_dest_base    (st_dest_base),
    .st_dest_pitch   (st_dest_pitch),
    .st_clip_tl      (st_clip_tl),
    .st_clip_br      (st_clip_br),
    .st_fg_color     (st_fg_color),
    .st_bg_color     (st_bg_color),
    .busy            (busy),
    .err_priv        (err_priv),
    .err_opcode      (err_opcode),
    .err_clear       (err_clear)
`ifdef BLIT_CMD_STATS_EN
    ,
    .stat_cmds       (stat_cmds),
    .stat_rejects    (stat_rejects)
`endif
  );

  always @(posedge clock) begin
    if (op_valid === 1'b1 && op_ready === 1'b1) begin
      xfers++;
      cap_code = op_code;
      cap_imm  = op_imm;
      cap_a0   = op_arg0;
      cap_a1   = op_arg1;
      cap_a2   = op_arg2;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one entry and returns just after the edge that consumed it.
  task automatic push(input logic p, input logic [31:0] w);
    int n = 0;
    cmd_queue_valid = 1'b1;
    cmd_queue_data  = {p, w};
    while (cmd_queue_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      total++;
      $display("FAIL push_timeout: ready stayed %b, required 1", cmd_queue_ready);
    end
    tick();
    cmd_queue_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    total++; if (cmd_queue_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_queue_ready); else passed++;
    total++; if (op_valid !== 1'b0) $display("FAIL reset_op_valid: got %b want 0", op_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if ({op_code, op_imm, op_arg0} !== 64'h0) $display("FAIL reset_op: got %h want 0", {op_code, op_imm, op_arg0}); else passed++;
    total++; if ({st_fg_color, st_dest_base} !== 64'h0) $display("FAIL reset_st: got %h want 0", {st_fg_color, st_dest_base}); else passed++;
    total++; if ({err_priv, err_opcode} !== 2'b00) $display("FAIL reset_err: got %b want 00", {err_priv, err_opcode}); else passed++;
  endtask

  task automatic test_set_fg();
    push(1'b0, 32'h0300FF00);
    total++; if (st_fg_color !== 32'h0000FF00) $display("FAIL set_fg: got %h want 0000ff00", st_fg_color); else passed++;
    total++; if (op_valid !== 1'b0) $display("FAIL set_fg_no_op: got %b want 0", op_valid); else passed++;
    total++; if (cmd_queue_ready !== 1'b1) $display("FAIL set_fg_ready: got %b want 1", cmd_queue_ready); else passed++;
  endtask

  task automatic test_back_to_back();
    push(1'b0, 32'h03000001);
    total++; if (st_fg_color !== 32'h00000001) $display("FAIL b2b_fg: got %h want 00000001", st_fg_color); else passed++;
    push(1'b0, 32'h04000002);
    total++; if (st_bg_color !== 32'h00000002) $display("FAIL b2b_bg: got %h want 00000002", st_bg_color); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL b2b_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_set_dest();
    push(1'b1, 32'h01000000);
    push(1'b1, 32'h80000000);
    push(1'b1, 32'h00000280);
    total++; if (cmd_queue_ready !== 1'b0) $display("FAIL dest_exec_ready: got %b want 0", cmd_queue_ready); else passed++;
    tick();
    total++; if (st_dest_base !== 32'h80000000) $display("FAIL dest_base: got %h want 80000000", st_dest_base); else passed++;
    total++; if (st_dest_pitch !== 16'h0280) $display("FAIL dest_pitch: got %h want 0280", st_dest_pitch); else passed++;
    total++; if (err_priv !== 1'b0) $display("FAIL dest_err_priv: got %b want 0", err_priv); else passed++;
    // Unprivileged source: arguments still consumed, registers untouched.
    push(1'b0, 32'h01000000);
    push(1'b1, 32'h12345678);
    push(1'b1, 32'h0000FFFF);
    tick();
    total++; if (st_dest_base !== 32'h80000000) $display("FAIL unpriv_base: got %h want 80000000", st_dest_base); else passed++;
    total++; if (st_dest_pitch !== 16'h0280) $display("FAIL unpriv_pitch: got %h want 0280", st_dest_pitch); else passed++;
    total++; if (err_priv !== 1'b1) $display("FAIL unpriv_err: got %b want 1", err_priv); else passed++;
    push(1'b0, 32'h0400ABCD);
    total++; if (st_bg_color !== 32'h0000ABCD) $display("FAIL after_reject_hdr: got %h want 0000abcd", st_bg_color); else passed++;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    total++; if (err_priv !== 1'b0) $display("FAIL err_priv_clear: got %b want 0", err_priv); else passed++;
  endtask

  task automatic test_fill_stall();
    int base = xfers;
    logic ok = 1'b1;
    op_ready = 1'b0;
    push(1'b0, 32'h10000000);
    push(1'b0, 32'h00100010);
    push(1'b0, 32'h00200020);
    total++; if (op_valid !== 1'b0) $display("FAIL fill_exec_valid: got %b want 0", op_valid); else passed++;
    tick();
    total++; if (op_valid !== 1'b1) $display("FAIL fill_valid: got %b want 1", op_valid); else passed++;
    total++; if ({op_code, op_imm} !== 32'h10000000) $display("FAIL fill_hdr: got %h want 10000000", {op_code, op_imm}); else passed++;
    total++; if ({op_arg0, op_arg1, op_arg2} !== {32'h00100010, 32'h00200020, 32'h0}) $display("FAIL fill_args: got %h %h %h want 00100010 00200020 00000000", op_arg0, op_arg1, op_arg2); else passed++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (op_valid !== 1'b1 || cmd_queue_ready !== 1'b0 || op_arg0 !== 32'h00100010 || op_arg1 !== 32'h00200020) ok = 1'b0;
    end
    total++; if (ok !== 1'b1) $display("FAIL fill_stall_stable: got %b want 1", ok); else passed++;
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    total++; if (op_valid !== 1'b0) $display("FAIL fill_done_valid: got %b want 0", op_valid); else passed++;
    total++; if (xfers - base !== 1) $display("FAIL fill_xfers: got %0d want 1", xfers - base); else passed++;
  endtask

  task automatic test_copy_gapped();
    int base = xfers;
    int n = 0;
    op_ready = 1'b1;
    push(1'b0, 32'h11ABCDEF);
    repeat (2) tick();
    push(1'b0, 32'h0000000A);
    repeat (3) tick();
    push(1'b0, 32'h0000000B);
    tick();
    push(1'b0, 32'h0000000C);
    while (busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    total++; if (n >= 20) $display("FAIL copy_timeout: busy %b want 0", busy); else passed++;
    total++; if (xfers - base !== 1) $display("FAIL copy_xfers: got %0d want 1", xfers - base); else passed++;
    total++; if ({cap_code, cap_imm} !== 32'h11ABCDEF) $display("FAIL copy_hdr: got %h want 11abcdef", {cap_code, cap_imm}); else passed++;
    total++; if ({cap_a0, cap_a1, cap_a2} !== {32'hA, 32'hB, 32'hC}) $display("FAIL copy_args: got %h %h %h want a b c", cap_a0, cap_a1, cap_a2); else passed++;
    op_ready = 1'b0;
  endtask

  task automatic test_unknown();
    push(1'b0, 32'h7F000000);
    total++; if (err_opcode !== 1'b1) $display("FAIL unk_err: got %b want 1", err_opcode); else passed++;
    total++; if (cmd_queue_ready !== 1'b1) $display("FAIL unk_ready: got %b want 1", cmd_queue_ready); else passed++;
    push(1'b0, 32'h00000000);
    total++; if (busy !== 1'b0) $display("FAIL nop_busy: got %b want 0", busy); else passed++;
    err_clear = 1'b1;
    push(1'b0, 32'h55000000);
    err_clear = 1'b0;
    total++; if (err_opcode !== 1'b1) $display("FAIL err_clear_vs_new: got %b want 1", err_opcode); else passed++;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    total++; if (err_opcode !== 1'b0) $display("FAIL err_opcode_clear: got %b want 0", err_opcode); else passed++;
  endtask

  task automatic test_reset_mid();
    int base = xfers;
    op_ready = 1'b1;
    push(1'b0, 32'h13000000);
    push(1'b0, 32'h00000001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b want 0", busy); else passed++;
    push(1'b0, 32'h03000011);
    total++; if (st_fg_color !== 32'h00000011) $display("FAIL mid_reset_hdr: got %h want 00000011", st_fg_color); else passed++;
    repeat (4) tick();
    total++; if (xfers - base !== 0) $display("FAIL mid_reset_no_op: got %0d want 0", xfers - base); else passed++;
    op_ready = 1'b0;
`ifdef BLIT_CMD_STATS_EN
    push(1'b0, 32'h7F000000);
    push(1'b0, 32'h01000000);
    push(1'b0, 32'h00000001);
    push(1'b0, 32'h00000002);
    tick();
    total++; if (stat_cmds !== 32'd3) $display("FAIL stat_cmds: got %0d want 3", stat_cmds); else passed++;
    total++; if (stat_rejects !== 16'd2) $display("FAIL stat_rejects: got %0d want 2", stat_rejects); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_set_fg();
    test_back_to_back();
    test_set_dest();
    test_fill_stall();
    test_copy_gapped();
    test_unknown();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
